// File: rtl/alu_issue_stage.sv
// ID/EX boundary for the RV32I EX-stage ALU: decodes the ALU op, forwards operands, registers them into EX.
// One-cycle latency; stall holds every EX register, flush loads a bubble, id_ready = !stall.
module alu_issue_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [6:0]        id_opcode,
  input  logic [2:0]        id_funct3,
  input  logic              id_funct7_5,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [REG_AW-1:0] id_rs1_addr,
  input  logic [REG_AW-1:0] id_rs2_addr,
  input  logic [REG_AW-1:0] id_rd_addr,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic              exm_wr,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic [XLEN-1:0]   exm_data,
  input  logic              mwb_wr,
  input  logic [REG_AW-1:0] mwb_rd,
  input  logic [XLEN-1:0]   mwb_data,
  output logic              id_ready,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_a,
  output logic [XLEN-1:0]   ex_b,
  output logic [3:0]        ex_alu_ctrl,
  output logic [XLEN-1:0]   ex_store_data,
  output logic [REG_AW-1:0] ex_rd_addr,
  output logic              ex_reg_write,
  output logic              ex_illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;
  localparam logic [3:0] ALU_ILL  = 4'b1111;

  localparam logic [1:0] ASEL_RS1  = 2'd0;
  localparam logic [1:0] ASEL_ZERO = 2'd1;
  localparam logic [1:0] ASEL_PC   = 2'd2;

  // For OP-IMM, bit 30 is an immediate bit for ADDI, so it only selects SUB on R-type.
  function automatic logic [3:0] f3_code(input logic [2:0] f3, input logic alt_sub,
                                         input logic alt_sra);
    logic [3:0] c;
    case (f3)
      3'b000:  c = alt_sub ? ALU_SUB : ALU_ADD;
      3'b001:  c = ALU_SLL;
      3'b010:  c = ALU_SLT;
      3'b011:  c = ALU_SLTU;
      3'b100:  c = ALU_XOR;
      3'b101:  c = alt_sra ? ALU_SRA : ALU_SRL;
      3'b110:  c = ALU_OR;
      default: c = ALU_AND;
    endcase
    return c;
  endfunction

  logic [3:0] ctrl_c;
  logic       ill_c;
  logic       wr_c;
  logic       use1_c;
  logic       use2_c;
  logic       bimm_c;
  logic [1:0] asel_c;

  always_comb begin
    ctrl_c = ALU_ADD;
    ill_c  = 1'b0;
    wr_c   = 1'b0;
    use1_c = 1'b0;
    use2_c = 1'b0;
    bimm_c = 1'b1;
    asel_c = ASEL_RS1;
    case (id_opcode)
      OPC_OP: begin
        ctrl_c = f3_code(id_funct3, id_funct7_5, id_funct7_5);
        wr_c   = 1'b1;
        use1_c = 1'b1;
        use2_c = 1'b1;
        bimm_c = 1'b0;
      end
      OPC_OP_IMM: begin
        ctrl_c = f3_code(id_funct3, 1'b0, id_funct7_5);
        wr_c   = 1'b1;
        use1_c = 1'b1;
      end
      OPC_LUI: begin
        wr_c   = 1'b1;
        asel_c = ASEL_ZERO;
      end
      OPC_AUIPC: begin
        wr_c   = 1'b1;
        asel_c = ASEL_PC;
      end
      OPC_LOAD: begin
        wr_c   = 1'b1;
        use1_c = 1'b1;
      end
      OPC_STORE: begin
        use1_c = 1'b1;
        use2_c = 1'b1;
      end
      OPC_BRANCH: begin
        use1_c = 1'b1;
        use2_c = 1'b1;
        bimm_c = 1'b0;
        case (id_funct3)
          3'b000, 3'b001: ctrl_c = ALU_SUB;
          3'b100, 3'b101: ctrl_c = ALU_SLT;
          3'b110, 3'b111: ctrl_c = ALU_SLTU;
          default: begin
            ctrl_c = ALU_ILL;
            ill_c  = 1'b1;
          end
        endcase
      end
      default: begin
        ctrl_c = ALU_ILL;
        ill_c  = 1'b1;
        wr_c   = 1'b0;
      end
    endcase
  end

  // EX/MEM is the younger producer, so it outranks MEM/WB; x0 always reads the RF value.
  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;

  always_comb begin
    rs1_fwd = id_rs1_data;
    if (use1_c && (id_rs1_addr != '0)) begin
      if (exm_wr && (exm_rd == id_rs1_addr))      rs1_fwd = exm_data;
      else if (mwb_wr && (mwb_rd == id_rs1_addr)) rs1_fwd = mwb_data;
    end
  end

  always_comb begin
    rs2_fwd = id_rs2_data;
    if (use2_c && (id_rs2_addr != '0)) begin
      if (exm_wr && (exm_rd == id_rs2_addr))      rs2_fwd = exm_data;
      else if (mwb_wr && (mwb_rd == id_rs2_addr)) rs2_fwd = mwb_data;
    end
  end

  // Illegal instructions carry zeroed operands so nothing stale leaks into EX.
  logic [XLEN-1:0] a_c;
  logic [XLEN-1:0] b_c;
  logic [XLEN-1:0] sd_c;

  always_comb begin
    a_c = rs1_fwd;
    if (asel_c == ASEL_ZERO)    a_c = '0;
    else if (asel_c == ASEL_PC) a_c = id_pc;
    b_c  = bimm_c ? id_imm : rs2_fwd;
    sd_c = rs2_fwd;
    if (ill_c) begin
      a_c  = '0;
      b_c  = '0;
      sd_c = '0;
    end
  end

  logic              valid_q, valid_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [3:0]        ctrl_q, ctrl_d;
  logic [XLEN-1:0]   sd_q, sd_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              ill_q, ill_d;

  always_comb begin
    valid_d = valid_q;
    a_d     = a_q;
    b_d     = b_q;
    ctrl_d  = ctrl_q;
    sd_d    = sd_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    ill_d   = ill_q;
    if (flush) begin
      valid_d = 1'b0;
      a_d     = '0;
      b_d     = '0;
      ctrl_d  = ALU_ADD;
      sd_d    = '0;
      rd_d    = '0;
      wr_d    = 1'b0;
      ill_d   = 1'b0;
    end else if (!stall) begin
      valid_d = id_valid;
      a_d     = a_c;
      b_d     = b_c;
      ctrl_d  = ctrl_c;
      sd_d    = sd_c;
      rd_d    = id_rd_addr;
      wr_d    = id_valid & wr_c & ~ill_c;
      ill_d   = id_valid & ill_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      ctrl_q  <= ALU_ADD;
      sd_q    <= '0;
      rd_q    <= '0;
      wr_q    <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ctrl_q  <= ctrl_d;
      sd_q    <= sd_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      ill_q   <= ill_d;
    end
  end

  assign id_ready      = ~stall;
  assign ex_valid      = valid_q;
  assign ex_a          = a_q;
  assign ex_b          = b_q;
  assign ex_alu_ctrl   = ctrl_q;
  assign ex_store_data = sd_q;
  assign ex_rd_addr    = rd_q;
  assign ex_reg_write  = wr_q;
  assign ex_illegal    = ill_q;

endmodule
